// File: rtl/counter_arbiter.sv
// counter_arbiter: round-robin owner of one shared saturating counter.
// Grants a requester, clears the counter, gates its x pulses until all ones, then pulses done.
module counter_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  x,
  input  logic [WIDTH-1:0] cnt_value,
  output logic             cnt_clear,
  output logic             cnt_enable,
  output logic [NREQ-1:0]  grant,
  output logic [NREQ-1:0]  done,
  output logic             busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLR   = 2'd1,
    S_COUNT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_r;
  logic [IW-1:0]   gidx_r;
  logic [IW-1:0]   last_r;
  logic [NREQ-1:0] grant_r;
  logic [NREQ-1:0] done_r;
  logic            busy_r;

  logic            z_s;
  logic            req_g_s;
  logic            x_g_s;
  logic            found_s;
  logic [IW-1:0]   win_s;

  // Round-robin search starting just after the last owner; returns {found, index}.
  function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] r, input logic [IW-1:0] last);
    logic [IW:0]   res;
    logic [IW-1:0] sel;
    int            idx;
    res = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(last) + i) % NREQ;
      sel = IW'(idx);
      if (!res[IW] && r[sel]) begin
        res = {1'b1, sel};
      end
    end
    return res;
  endfunction

  assign z_s              = (cnt_value == {WIDTH{1'b1}});
  assign req_g_s          = req[gidx_r];
  assign x_g_s            = x[gidx_r];
  assign {found_s, win_s} = rr_pick(req, last_r);

  // The counter is held clear during reset; enable is masked by clear so both never coincide.
  assign cnt_clear  = clear | (state_r == S_CLR);
  assign cnt_enable = ~clear & (state_r == S_COUNT) & x_g_s & ~z_s;

  assign grant = grant_r;
  assign done  = done_r;
  assign busy  = busy_r;

  // Sequencer: IDLE -> CLR -> COUNT -> DONE, with abort on a dropped request.
  always_ff @(negedge clock) begin
    if (clear) begin
      state_r <= S_IDLE;
      grant_r <= '0;
      done_r  <= '0;
      busy_r  <= 1'b0;
      gidx_r  <= '0;
      last_r  <= IW'(NREQ - 1);
    end else begin
      case (state_r)
        S_IDLE: begin
          done_r <= '0;
          if (found_s) begin
            state_r <= S_CLR;
            gidx_r  <= win_s;
            grant_r <= {{(NREQ-1){1'b0}}, 1'b1} << win_s;
            busy_r  <= 1'b1;
          end else begin
            state_r <= S_IDLE;
            grant_r <= '0;
            busy_r  <= 1'b0;
          end
        end
        S_CLR: begin
          if (!req_g_s) begin
            state_r <= S_IDLE;
            grant_r <= '0;
            busy_r  <= 1'b0;
            last_r  <= gidx_r;
          end else begin
            state_r <= S_COUNT;
          end
        end
        S_COUNT: begin
          // Abort wins over saturation in the same cycle.
          if (!req_g_s) begin
            state_r <= S_IDLE;
            grant_r <= '0;
            busy_r  <= 1'b0;
            last_r  <= gidx_r;
          end else if (z_s) begin
            state_r <= S_DONE;
            done_r  <= grant_r;
          end else begin
            state_r <= S_COUNT;
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
          grant_r <= '0;
          done_r  <= '0;
          busy_r  <= 1'b0;
          last_r  <= gidx_r;
        end
        default: begin
          state_r <= S_IDLE;
          grant_r <= '0;
          done_r  <= '0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter: vector table, hand-written corner sequences and a
// randomized run checked every cycle against a transaction-level reference model.
module tb_counter_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam int TOPV  = (1 << WIDTH) - 1;

  logic             clock = 1'b0;
  logic             clear;
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  x;
  logic [WIDTH-1:0] cnt_value;
  logic             cnt_clear;
  logic             cnt_enable;
  logic [NREQ-1:0]  grant;
  logic [NREQ-1:0]  done;
  logic             busy;

  int n_checks = 0;
  int n_errors = 0;
  bit model_on = 1'b0;

  always #5 clock = ~clock;

  counter_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clock(clock), .clear(clear), .req(req), .x(x), .cnt_value(cnt_value),
    .cnt_clear(cnt_clear), .cnt_enable(cnt_enable), .grant(grant), .done(done), .busy(busy)
  );

  // The shared external counter, stepped on the same falling edge.
  always @(negedge clock) begin
    if (cnt_clear) cnt_value <= '0;
    else if (cnt_enable) cnt_value <= cnt_value + 1'b1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the counter, whether it was cleared, whether done is showing.
  int m_owner = -1;
  int m_last  = NREQ - 1;
  int m_cnt   = 0;
  bit m_cleared = 1'b0;
  bit m_done    = 1'b0;

  function automatic bit m_clr();
    return clear || (m_owner >= 0 && !m_cleared && !m_done);
  endfunction

  function automatic bit m_en();
    return !clear && m_owner >= 0 && m_cleared && !m_done && x[m_owner] && m_cnt != TOPV;
  endfunction

  task automatic model_step();
    int nxt;
    nxt = m_clr() ? 0 : (m_en() ? m_cnt + 1 : m_cnt);
    if (clear) begin
      m_owner = -1; m_cleared = 1'b0; m_done = 1'b0; m_last = NREQ - 1;
    end else if (m_done) begin
      m_last = m_owner; m_owner = -1; m_done = 1'b0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (m_owner < 0 && req[(m_last + k) % NREQ]) begin
          m_owner = (m_last + k) % NREQ; m_cleared = 1'b0;
        end
      end
    end else if (!req[m_owner]) begin
      m_last = m_owner; m_owner = -1;
    end else if (!m_cleared) begin
      m_cleared = 1'b1;
    end else if (m_cnt == TOPV) begin
      m_done = 1'b1;
    end
    m_cnt = nxt;
  endtask

  initial forever begin
    @(negedge clock);
    model_step();
  end

  // Every cycle, mid-way between falling edges, compare all outputs with the model.
  initial forever begin
    @(posedge clock);
    #1;
    if (model_on) begin
      chk("model_grant", grant, m_owner >= 0 ? (1 << m_owner) : 0);
      chk("model_done", done, m_done ? (1 << m_owner) : 0);
      chk("model_busy", busy, m_owner >= 0);
      chk("model_cnt_clear", cnt_clear, m_clr());
      chk("model_cnt_enable", cnt_enable, m_en());
      chk("model_cnt_value", cnt_value, m_cnt);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  typedef struct {
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  x;
    logic             clr;
    logic [NREQ-1:0]  grant;
    logic [NREQ-1:0]  done;
    logic             busy;
    logic             cclr;
    logic             cen;
    logic [WIDTH-1:0] cnt;
  } vec_t;

  vec_t vec [12];

  task automatic do_reset();
    @(posedge clock); clear = 1'b1; req = '0; x = '0;
    @(posedge clock); clear = 1'b0;
  endtask

  task automatic run_txn(input int g, input bit toggle, input int exp_edge);
    logic [NREQ-1:0] oh;
    int enables, clrs;
    bit seen;
    oh = '0; oh[g] = 1'b1; enables = 0; clrs = 0; seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(posedge clock);
      req = oh; x = '1;
      if (toggle) x[g] = k[0];
      #1;
      if (cnt_enable) enables++;
      if (cnt_clear) clrs++;
      @(negedge clock); #1;
      if (k == 0) chk("txn_grant", grant, oh);
      if (!toggle && k >= 1 && k <= 16) chk("txn_ramp", cnt_value, k - 1);
      if (done != '0) begin
        seen = 1'b1;
        chk("txn_done_edge", k, exp_edge);
        chk("txn_done_bit", done, oh);
      end
    end
    chk("txn_done_seen", seen, 1);
    chk("txn_enables", enables, 15);
    chk("txn_clear_cycles", clrs, 1);
    chk("txn_final_cnt", cnt_value, TOPV);
    @(negedge clock); #1;
    chk("txn_release_grant", grant, 0);
    chk("txn_release_busy", busy, 0);
    chk("txn_release_done", done, 0);
    @(posedge clock); req = '0; x = '0;
  endtask

  initial begin
    bit found;
    clear = 1'b1; req = '0; x = '0;
    vec[0]  = '{4'b0010, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0};
    vec[1]  = '{4'b0010, 4'b0000, 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b1, 1'b0, 4'd0};
    vec[2]  = '{4'b0010, 4'b0010, 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b0, 1'b1, 4'd0};
    vec[3]  = '{4'b0010, 4'b1101, 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b0, 1'b0, 4'd1};
    vec[4]  = '{4'b0010, 4'b0010, 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b0, 1'b1, 4'd1};
    vec[5]  = '{4'b0000, 4'b0010, 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b0, 1'b1, 4'd2};
    vec[6]  = '{4'b0011, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd3};
    vec[7]  = '{4'b0011, 4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0, 4'd3};
    vec[8]  = '{4'b0011, 4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 4'd0};
    vec[9]  = '{4'b0011, 4'b0001, 1'b1, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0, 4'd0};
    vec[10] = '{4'b0110, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0};
    vec[11] = '{4'b0110, 4'b0000, 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b1, 1'b0, 4'd0};

    repeat (2) @(negedge clock);
    @(posedge clock); #1;
    chk("reset_grant", grant, 0);
    chk("reset_done", done, 0);
    chk("reset_busy", busy, 0);
    chk("reset_cnt_clear", cnt_clear, 1);
    chk("reset_cnt_enable", cnt_enable, 0);
    chk("reset_cnt_value", cnt_value, 0);
    model_on = 1'b1;

    for (int i = 0; i < 12; i++) begin
      @(posedge clock);
      req = vec[i].req; x = vec[i].x; clear = vec[i].clr;
      #1;
      chk("vec_grant", grant, vec[i].grant);
      chk("vec_done", done, vec[i].done);
      chk("vec_busy", busy, vec[i].busy);
      chk("vec_cnt_clear", cnt_clear, vec[i].cclr);
      chk("vec_cnt_enable", cnt_enable, vec[i].cen);
      chk("vec_cnt_value", cnt_value, vec[i].cnt);
    end

    // Single requester, x held high: done 17 edges after the request is sampled.
    do_reset();
    run_txn(0, 1'b0, 17);

    // All four requesting from reset exit: strict rotation with an idle gap each time.
    @(posedge clock); clear = 1'b1; req = 4'b1111; x = '1;
    @(posedge clock); clear = 1'b0;
    for (int t = 0; t < 5; t++) begin
      found = 1'b0;
      for (int w = 0; w < 4 && !found; w++) begin
        @(negedge clock); #1;
        if (grant != '0) found = 1'b1;
      end
      chk("rr_grant", grant, 1 << (t % NREQ));
      found = 1'b0;
      for (int w = 0; w < 40 && !found; w++) begin
        @(negedge clock); #1;
        if (done != '0) found = 1'b1;
      end
      chk("rr_done", done, 1 << (t % NREQ));
      @(negedge clock); #1;
      chk("rr_idle_gap", busy, 0);
    end
    @(posedge clock); req = '0; x = '0;

    // x[g] toggling with the other x bits high: exactly 15 counts, done at edge 32.
    run_txn(1, 1'b1, 32);

    // Request dropped in the cycle the counter reads all ones: no done.
    @(posedge clock); req = 4'b1000; x = '1;
    found = 1'b0;
    for (int w = 0; w < 40 && !found; w++) begin
      @(negedge clock); #1;
      if (busy && !cnt_clear && cnt_value == WIDTH'(TOPV) && done == '0) found = 1'b1;
    end
    chk("zabort_reached", found, 1);
    @(posedge clock); req = '0;
    @(negedge clock); #1;
    chk("zabort_grant", grant, 0);
    chk("zabort_done", done, 0);
    chk("zabort_busy", busy, 0);
    @(negedge clock); #1;
    chk("zabort_no_late_done", done, 0);

    // Request dropped at count 7, then round-robin resumes after the aborted owner.
    @(posedge clock); req = 4'b0100; x = '1;
    found = 1'b0;
    for (int w = 0; w < 40 && !found; w++) begin
      @(negedge clock); #1;
      if (busy && !cnt_clear && cnt_value == 4'd7) found = 1'b1;
    end
    chk("abort7_reached", found, 1);
    @(posedge clock); req = '0;
    @(negedge clock); #1;
    chk("abort7_grant", grant, 0);
    chk("abort7_done", done, 0);
    @(posedge clock); req = 4'b1011;
    @(negedge clock); #1;
    chk("abort7_next_rr", grant, 4'b1000);

    // Clear at count 9 ends the transaction; req[0] then has top priority again.
    found = 1'b0;
    for (int w = 0; w < 40 && !found; w++) begin
      @(negedge clock); #1;
      if (busy && !cnt_clear && cnt_value == 4'd9) found = 1'b1;
    end
    chk("clr9_reached", found, 1);
    @(posedge clock); clear = 1'b1; req = 4'b1111;
    @(negedge clock); #1;
    chk("clr9_grant", grant, 0);
    chk("clr9_busy", busy, 0);
    chk("clr9_cnt", cnt_value, 0);
    chk("clr9_done", done, 0);
    @(posedge clock); clear = 1'b0;
    @(negedge clock); #1;
    chk("clr9_winner", grant, 4'b0001);
    @(posedge clock); req = '0;

    // Randomized traffic; the model process compares every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clock);
      clear = ($urandom_range(0, 399) == 0);
      for (int b = 0; b < NREQ; b++) begin
        if ($urandom_range(0, 24) == 0) req[b] = ~req[b];
      end
      x = NREQ'($urandom) | NREQ'($urandom);
    end
    @(posedge clock); #2;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/counter_arbiter.md
# counter_arbiter

Round-robin arbiter and sequencer that shares one external 4-bit synchronous counter (T-flip-flop counter with synchronous clear and count enable) among NREQ requesters. It grants the counter to one requester at a time, clears it, and gates that requester's X pulses into it until the count saturates (all ones). It then pulses the requester's done line and releases the counter. It sits between the requester control units and the counter/Z-detect datapath.

## Interface
- NREQ, 4: number of requesters (2..8).
- WIDTH, 4: counter width; terminal count is all ones (15 for WIDTH=4).

- clock  input  1  system clock; all state updates on the falling edge.
- clear  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester request; level, held for the whole transaction.
- x  input  NREQ  per-requester count pulse; only the granted bit is used.
- cnt_value  input  WIDTH  current value of the shared counter.
- cnt_clear  output  1  synchronous clear to the counter.
- cnt_enable  output  1  count enable to the counter.
- grant  output  NREQ  one-hot registered grant; all zero when idle.
- done  output  NREQ  one-cycle completion pulse for the granted requester.
- busy  output  1  high in any state other than IDLE.

## Operation
- Z = (cnt_value == all ones), decoded internally.
- The FSM has four states: IDLE, CLR, COUNT, DONE. The encoding is free.
- IDLE:
  - If req is nonzero, select the winner by round-robin. Search starts at last+1 and wraps modulo NREQ.
  - Latch the one-hot winner into grant and move to CLR.
  - If req is zero, stay in IDLE.
- CLR:
  - cnt_clear=1 for exactly one cycle.
  - Next state: COUNT, unless req[g] is low (abort, see below).
- COUNT:
  - cnt_enable = x[g] & ~Z, combinational.
  - Non-granted x bits are ignored.
  - If Z is high, go to DONE.
- DONE:
  - done[g]=1, grant is held, next state is IDLE.
- Leaving DONE or aborting:
  - grant clears to 0 and last takes the value g.
- Abort:
  - If req[g] is low in CLR or COUNT, the next edge returns to IDLE with no done, grant goes to 0, and last=g.
  - Abort takes priority over Z in the same cycle.
- cnt_clear = (state==CLR) | clear. The counter is cleared while the block is in reset.
- cnt_enable is never high outside COUNT.
- cnt_clear and cnt_enable are never high together.
- done is one-hot or zero and is only ever high in DONE.

## Timing
- Reset (clear high at an edge):
  - state=IDLE, grant=0, done=0, busy=0, last=NREQ-1, so req[0] has top priority after reset.
  - cnt_enable=0, cnt_clear=1 while clear is high.
- Reset mid-transaction: the transaction ends at that edge. No done is issued.
- Latency with x[g] held high:
  - edge 0: req is sampled, grant appears.
  - edge 1: CLR, counter goes to 0.
  - edges 2..16: counter counts 1..15.
  - edge 17: DONE is entered, done is high for one cycle.
  - edge 18: IDLE.
  - Total: done is high 17 edges after req was sampled in IDLE.
- Gaps in x stretch COUNT one cycle per low x cycle. No other effect.
- Back to back:
  - There is at least one IDLE cycle between DONE and the next grant.
  - A requester that keeps req high after done is re-granted only if no other requester is pending.
- Z already true on entry to COUNT cannot occur, because CLR precedes it.
- If Z is true in COUNT, cnt_enable=0, so the counter never wraps past all ones.

## Test plan
- Reset, then req=4'b0001 with x[0]=1 → grant=0001 after 1 edge, cnt_clear for 1 cycle, cnt_value ramps 0..15, done[0] pulses at edge 17, grant=0 and busy=0 at edge 18.
- Simultaneous req=4'b1111 at reset exit → grants in order 0001, 0010, 0100, 1000, 0001, each with 15 counts and one done pulse.
- x[g] toggling 1,0 each cycle while other x bits are held at 1 → exactly 15 enables, done at edge 32, cnt_value never exceeds 15 and never wraps.
- req[g] dropped when cnt_value=7 → next edge grant=0 with no done pulse, and the next request is served by round-robin from g+1.
- req[g] dropped in the same cycle Z=1 → no done pulse, return to IDLE.
- clear asserted mid-COUNT at cnt_value=9 → at that edge grant=0, busy=0 and cnt_value=0; req[0] wins next even if last was 2.
